// File: rtl/clock_pkg.sv
// Shared definitions for the clock/alarm codebase.
// Contents:
//   ringer_state_t  - alarm_ringer FSM states (2-bit)
//   DEF_*           - default values for the alarm_ringer parameters
//   cnt_width()     - counter width for a given terminal count, never below 1 bit
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    HOLD   = 2'd3
  } ringer_state_t;

  localparam int DEF_BEEP_HALF_PERIOD = 25_000_000;
  localparam int DEF_RING_TIMEOUT     = 60;
  localparam int DEF_SNOOZE_SECS      = 300;
  localparam int DEF_MAX_SNOOZE       = 3;

  // A counter that must reach terminal-1 needs $clog2(terminal) bits;
  // a terminal of 1 still needs one bit to hold the value 0.
  function automatic int cnt_width(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a rising-edge detector on the synchronized level.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   din    in   asynchronous input level
//   level  out  synchronized level (2 clk edges after din)
//   rise   out  high for one clk when level goes 0 -> 1
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_q;

  // Synchronizer chain plus a delayed copy of the synchronized level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_q <= 1'b0;
    end else begin
      r_meta   <= din;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
    end
  end

  // rise is formed from two flops, so it is visible in the same cycle as the
  // new level and the FSM can act on it without an added cycle.
  assign level = r_sync;
  assign rise  = r_sync & ~r_sync_q;

endmodule

// File: rtl/alarm_ringer.sv
// Turns the alarm block's buzzer request level into a beeping buzzer drive,
// handles dismiss/snooze buttons, ring timeout with auto-snooze and a snooze
// limit that forces a dismiss.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   tick_1s      in   one-clk strobe per second, synchronous to clk
//   buzz_req     in   alarm request level (asynchronous)
//   dismiss      in   debounced startstop button level (asynchronous)
//   snooze       in   debounced snooze button level (asynchronous)
//   buzzer       out  buzzer drive, on/off every BEEP_HALF_PERIOD clks while ringing
//   ringing      out  high in RING
//   snoozing     out  high in SNOOZE
//   alarm_clear  out  one-clk pulse on entry to HOLD
//   snooze_cnt   out  snoozes used in the current alarm event
module alarm_ringer
  import clock_pkg::*;
#(
  parameter int BEEP_HALF_PERIOD = DEF_BEEP_HALF_PERIOD,
  parameter int RING_TIMEOUT     = DEF_RING_TIMEOUT,
  parameter int SNOOZE_SECS      = DEF_SNOOZE_SECS,
  parameter int MAX_SNOOZE       = DEF_MAX_SNOOZE
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tick_1s,
  input  logic                              buzz_req,
  input  logic                              dismiss,
  input  logic                              snooze,
  output logic                              buzzer,
  output logic                              ringing,
  output logic                              snoozing,
  output logic                              alarm_clear,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_cnt
);

  localparam int CNT_W  = $clog2(MAX_SNOOZE + 1);
  localparam int BEEP_W = cnt_width(BEEP_HALF_PERIOD);
  localparam int SEC_W  = cnt_width((RING_TIMEOUT > SNOOZE_SECS) ? RING_TIMEOUT : SNOOZE_SECS);

  localparam logic [BEEP_W-1:0] BEEP_LAST   = BEEP_W'(BEEP_HALF_PERIOD - 1);
  localparam logic [SEC_W-1:0]  RING_LAST   = SEC_W'(RING_TIMEOUT - 1);
  localparam logic [SEC_W-1:0]  SNOOZE_LAST = SEC_W'(SNOOZE_SECS - 1);
  localparam logic [CNT_W-1:0]  SNOOZE_MAX  = CNT_W'(MAX_SNOOZE);

  logic w_buzz_lvl;
  logic w_buzz_rise_unused;
  logic w_dis_lvl_unused;
  logic w_dis_rise;
  logic w_snz_lvl_unused;
  logic w_snz_rise;

  sync_edge u_sync_buzz (
    .clk   (clk),
    .reset (reset),
    .din   (buzz_req),
    .level (w_buzz_lvl),
    .rise  (w_buzz_rise_unused)
  );

  sync_edge u_sync_dismiss (
    .clk   (clk),
    .reset (reset),
    .din   (dismiss),
    .level (w_dis_lvl_unused),
    .rise  (w_dis_rise)
  );

  sync_edge u_sync_snooze (
    .clk   (clk),
    .reset (reset),
    .din   (snooze),
    .level (w_snz_lvl_unused),
    .rise  (w_snz_rise)
  );

  ringer_state_t     r_state;
  logic [BEEP_W-1:0] r_beep_cnt;
  logic [SEC_W-1:0]  r_sec_cnt;
  logic              r_buzzer;
  logic              r_ringing;
  logic              r_snoozing;
  logic              r_alarm_clear;
  logic [CNT_W-1:0]  r_snooze_cnt;

  logic w_timeout;
  logic w_expiry;
  logic w_snooze_req;
  logic w_snooze_ok;

  // A timeout behaves exactly like a snooze press; once the snooze budget is
  // spent, either one turns into a forced dismiss.
  assign w_timeout    = tick_1s & (r_sec_cnt == RING_LAST);
  assign w_expiry     = tick_1s & (r_sec_cnt == SNOOZE_LAST);
  assign w_snooze_req = w_snz_rise | w_timeout;
  assign w_snooze_ok  = (r_snooze_cnt < SNOOZE_MAX);

  // Ringer FSM with registered outputs; counters clear on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_beep_cnt    <= '0;
      r_sec_cnt     <= '0;
      r_buzzer      <= 1'b0;
      r_ringing     <= 1'b0;
      r_snoozing    <= 1'b0;
      r_alarm_clear <= 1'b0;
      r_snooze_cnt  <= '0;
    end else begin
      r_alarm_clear <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_buzz_lvl) begin
            r_state    <= RING;
            r_beep_cnt <= '0;
            r_sec_cnt  <= '0;
            r_buzzer   <= 1'b1;
            r_ringing  <= 1'b1;
          end
        end

        RING: begin
          if (!w_buzz_lvl) begin
            // Alarm withdrawn externally: no clear pulse needed.
            r_state      <= IDLE;
            r_beep_cnt   <= '0;
            r_sec_cnt    <= '0;
            r_buzzer     <= 1'b0;
            r_ringing    <= 1'b0;
            r_snooze_cnt <= '0;
          end else if (w_dis_rise || (w_snooze_req && !w_snooze_ok)) begin
            r_state       <= HOLD;
            r_beep_cnt    <= '0;
            r_sec_cnt     <= '0;
            r_buzzer      <= 1'b0;
            r_ringing     <= 1'b0;
            r_alarm_clear <= 1'b1;
          end else if (w_snooze_req) begin
            r_state      <= SNOOZE;
            r_beep_cnt   <= '0;
            r_sec_cnt    <= '0;
            r_buzzer     <= 1'b0;
            r_ringing    <= 1'b0;
            r_snoozing   <= 1'b1;
            r_snooze_cnt <= r_snooze_cnt + CNT_W'(1);
          end else begin
            if (r_beep_cnt == BEEP_LAST) begin
              r_beep_cnt <= '0;
              r_buzzer   <= ~r_buzzer;
            end else begin
              r_beep_cnt <= r_beep_cnt + BEEP_W'(1);
            end
            if (tick_1s) begin
              r_sec_cnt <= r_sec_cnt + SEC_W'(1);
            end
          end
        end

        SNOOZE: begin
          if (!w_buzz_lvl) begin
            r_state      <= IDLE;
            r_sec_cnt    <= '0;
            r_snoozing   <= 1'b0;
            r_snooze_cnt <= '0;
          end else if (w_dis_rise) begin
            r_state       <= HOLD;
            r_sec_cnt     <= '0;
            r_snoozing    <= 1'b0;
            r_alarm_clear <= 1'b1;
          end else if (w_expiry) begin
            // Pattern restarts at the "on" half on every return to RING.
            r_state    <= RING;
            r_beep_cnt <= '0;
            r_sec_cnt  <= '0;
            r_buzzer   <= 1'b1;
            r_ringing  <= 1'b1;
            r_snoozing <= 1'b0;
          end else if (tick_1s) begin
            r_sec_cnt <= r_sec_cnt + SEC_W'(1);
          end
        end

        HOLD: begin
          // Stay here until the alarm block has consumed alarm_clear.
          if (!w_buzz_lvl) begin
            r_state      <= IDLE;
            r_snooze_cnt <= '0;
          end
        end

        default: begin
          r_state       <= IDLE;
          r_beep_cnt    <= '0;
          r_sec_cnt     <= '0;
          r_buzzer      <= 1'b0;
          r_ringing     <= 1'b0;
          r_snoozing    <= 1'b0;
          r_snooze_cnt  <= '0;
        end
      endcase
    end
  end

  assign buzzer      = r_buzzer;
  assign ringing     = r_ringing;
  assign snoozing    = r_snoozing;
  assign alarm_clear = r_alarm_clear;
  assign snooze_cnt  = r_snooze_cnt;

endmodule

// File: tb/tb_alarm_ringer.sv
module tb_alarm_ringer;

  localparam int HALF  = 4;
  localparam int RT    = 3;
  localparam int SS    = 2;
  localparam int MAXS  = 2;
  localparam int TICKP = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1s;
  logic       buzz_req;
  logic       dismiss;
  logic       snooze;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic       alarm_clear;
  logic [1:0] snooze_cnt;

  alarm_ringer #(
    .BEEP_HALF_PERIOD (HALF),
    .RING_TIMEOUT     (RT),
    .SNOOZE_SECS      (SS),
    .MAX_SNOOZE       (MAXS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1s     (tick_1s),
    .buzz_req    (buzz_req),
    .dismiss     (dismiss),
    .snooze      (snooze),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .alarm_clear (alarm_clear),
    .snooze_cnt  (snooze_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle_no = 0;

  // Reference model: what the user experiences, in terms of modes, time spent
  // ringing (for the beep pattern) and seconds elapsed in the current mode.
  typedef enum int {M_IDLE, M_RING, M_SNOOZE, M_HOLD} mode_t;
  mode_t m_mode;
  int    m_age;
  int    m_secs;
  int    m_cnt;
  bit    m_clear;
  // Input history as seen by the DUT's synchronizers.
  bit m_b1, m_b2, m_d1, m_d2, m_d3, m_s1, m_s2, m_s3;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle_no, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_age = 0; m_secs = 0; m_cnt = 0; m_clear = 0;
    m_b1 = 0; m_b2 = 0; m_d1 = 0; m_d2 = 0; m_d3 = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0;
  endtask

  task automatic go_snooze_or_dismiss();
    if (m_cnt < MAXS) begin
      m_mode = M_SNOOZE; m_cnt++; m_secs = 0;
    end else begin
      m_mode = M_HOLD; m_clear = 1;
    end
  endtask

  task automatic model_step();
    bit lvl, dr, sr, tk;
    lvl = m_b2;
    dr  = m_d2 && !m_d3;
    sr  = m_s2 && !m_s3;
    tk  = tick_1s;
    m_clear = 0;
    case (m_mode)
      M_IDLE:   if (lvl) begin m_mode = M_RING; m_age = 0; m_secs = 0; end
      M_RING: begin
        if (!lvl) begin m_mode = M_IDLE; m_cnt = 0; end
        else if (dr) begin m_mode = M_HOLD; m_clear = 1; end
        else if (sr || (tk && m_secs + 1 == RT)) go_snooze_or_dismiss();
        else begin m_age++; if (tk) m_secs++; end
      end
      M_SNOOZE: begin
        if (!lvl) begin m_mode = M_IDLE; m_cnt = 0; end
        else if (dr) begin m_mode = M_HOLD; m_clear = 1; end
        else if (tk && m_secs + 1 == SS) begin m_mode = M_RING; m_age = 0; m_secs = 0; end
        else if (tk) m_secs++;
      end
      default:  if (!lvl) begin m_mode = M_IDLE; m_cnt = 0; end
    endcase
    m_b2 = m_b1; m_b1 = buzz_req;
    m_d3 = m_d2; m_d2 = m_d1; m_d1 = dismiss;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = snooze;
  endtask

  task automatic check_model();
    bit exp_buz;
    exp_buz = (m_mode == M_RING) && (((m_age / HALF) % 2) == 0);
    chk("buzzer",      {7'd0, buzzer},      {7'd0, exp_buz});
    chk("ringing",     {7'd0, ringing},     {7'd0, m_mode == M_RING});
    chk("snoozing",    {7'd0, snoozing},    {7'd0, m_mode == M_SNOOZE});
    chk("alarm_clear", {7'd0, alarm_clear}, {7'd0, m_clear});
    chk("snooze_cnt",  {6'd0, snooze_cnt},  8'(m_cnt));
  endtask

  // One clock: inputs are stable from the previous negedge, outputs checked at the next.
  task automatic cyc();
    tick_1s = ((cycle_no % TICKP) == (TICKP - 1));
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    cycle_no++;
    tick_1s = 1'b0;
    check_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    reset = 1'b1; tick_1s = 1'b0; buzz_req = 1'b0; dismiss = 1'b0; snooze = 1'b0;
    model_reset();
    @(negedge clk);
    run(2);
    chk("reset_ringing", {7'd0, ringing}, 8'd0);
    chk("reset_cnt", {6'd0, snooze_cnt}, 8'd0);
    reset = 1'b0;
    run(8);

    // Alarm starts: ringing appears on the third edge.
    buzz_req = 1'b1;
    run(2);
    chk("ring_latency_early", {7'd0, ringing}, 8'd0);
    run(1);
    chk("ring_entry_ringing", {7'd0, ringing}, 8'd1);
    chk("ring_entry_buzzer", {7'd0, buzzer}, 8'd1);
    chk("ring_entry_cnt", {6'd0, snooze_cnt}, 8'd0);
    run(6);

    // Dismiss while ringing.
    dismiss = 1'b1;
    run(2);
    chk("dismiss_early", {7'd0, alarm_clear}, 8'd0);
    run(1);
    chk("dismiss_clear", {7'd0, alarm_clear}, 8'd1);
    chk("dismiss_buzzer", {7'd0, buzzer}, 8'd0);
    run(1);
    chk("dismiss_clear_width", {7'd0, alarm_clear}, 8'd0);
    dismiss = 1'b0;
    run(4);
    buzz_req = 1'b0;
    run(6);

    // Manual snoozes up to the limit, then forced dismiss.
    buzz_req = 1'b1;
    run(8);
    for (int k = 0; k < 3; k++) begin
      snooze = 1'b1; run(4);
      snooze = 1'b0; run(50);
    end
    buzz_req = 1'b0;
    run(6);

    // No user input: auto-snooze twice, then forced dismiss on third timeout.
    buzz_req = 1'b1;
    run(300);
    chk("auto_final_cnt", {6'd0, snooze_cnt}, 8'd2);
    chk("auto_final_ringing", {7'd0, ringing}, 8'd0);
    chk("auto_final_snoozing", {7'd0, snoozing}, 8'd0);
    buzz_req = 1'b0;
    run(6);

    // Simultaneous dismiss and snooze edges.
    buzz_req = 1'b1;
    run(6);
    dismiss = 1'b1; snooze = 1'b1;
    run(3);
    chk("simul_clear", {7'd0, alarm_clear}, 8'd1);
    chk("simul_cnt", {6'd0, snooze_cnt}, 8'd0);
    dismiss = 1'b0; snooze = 1'b0;
    buzz_req = 1'b0;
    run(6);

    // buzz_req withdrawn during SNOOZE.
    buzz_req = 1'b1;
    run(6);
    snooze = 1'b1;
    run(4);
    snooze = 1'b0;
    buzz_req = 1'b0;
    run(6);
    chk("withdraw_cnt", {6'd0, snooze_cnt}, 8'd0);

    // Reset mid-ring drops everything at once.
    buzz_req = 1'b1;
    run(10);
    reset = 1'b1;
    #1;
    chk("async_rst_buzzer", {7'd0, buzzer}, 8'd0);
    chk("async_rst_ringing", {7'd0, ringing}, 8'd0);
    chk("async_rst_clear", {7'd0, alarm_clear}, 8'd0);
    model_reset();
    @(negedge clk);
    run(2);
    reset = 1'b0;
    run(3);
    chk("post_rst_ringing", {7'd0, ringing}, 8'd1);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 79) == 0) buzz_req = ~buzz_req;
      if ($urandom_range(0, 11) == 0) dismiss = ~dismiss;
      if ($urandom_range(0, 7) == 0) snooze = ~snooze;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
